lcd_row_writer: RTL and testbench

- Downstream consumer of the 16-character ASCII row formatter (the "SENS: XXX" line).
- Drives an HD44780-compatible 16x2 character LCD over an 8-bit parallel bus in write-only mode.
- On power-up, runs the LCD init sequence.
- After init, accepts 128-bit rows through a start/busy handshake and writes them to line 1 or line 2 with software-timed E strobes.

---
 rtl/lcd_row_writer.sv | 167 ++++++++++++++++
 tb/tb_lcd_row_writer.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/lcd_row_writer.sv
// lcd_row_writer: HD44780 8-bit write-only driver; power-up init, then 16-char row writes to line 1/2.
// Optional LCD_SKIP_SAME_EN: skip rewriting a line whose last written row is unchanged.
module lcd_row_writer #(
   parameter int POWERUP_CYC    = 1000000,
   parameter int E_PULSE_CYC    = 25,
   parameter int CMD_WAIT_CYC   = 2500,
   parameter int CLEAR_WAIT_CYC = 100000
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [127:0] ascii_row,
   input  logic         row_sel,
   input  logic         start,
   output logic         ready,
   output logic         busy,
   output logic         done,
   output logic         lcd_rs,
   output logic         lcd_rw,
   output logic         lcd_e,
   output logic [7:0]   lcd_data
);
   localparam int MAX_CYC = POWERUP_CYC > CLEAR_WAIT_CYC ? POWERUP_CYC : CLEAR_WAIT_CYC;
   localparam int CW = $clog2(MAX_CYC) + 1;
   typedef enum logic [2:0] {PWRUP, INIT, IDLE, WRITE, FIN} state_t;
   typedef enum logic [1:0] {SETUP, EHI, HOLD} phase_t;
   state_t state_q, state_d;
   phase_t ph_q, ph_d;
   logic [CW-1:0] cnt_q, cnt_d, hold_end;
   logic [4:0] idx_q, idx_d;
   logic [127:0] row_q, row_d;
   logic sel_q, sel_d, e_q, e_d, rs_q, rs_d, done_q, done_d, ready_q, ready_d, busy_q, busy_d;
   logic [7:0] data_q, data_d, next_byte;
   logic last_byte, hit;
   assign hold_end = (!rs_q && data_q == 8'h01) ? CW'(CLEAR_WAIT_CYC - 1) : CW'(CMD_WAIT_CYC - 1);
   assign last_byte = (state_q == INIT) ? idx_q == 5'd3 : idx_q == 5'd16;
   // idx_q is the byte just finished; character idx_q+1 sits at [127-8*idx_q -: 8]
   assign next_byte = (state_q == INIT) ? (idx_q == 5'd0 ? 8'h0C : idx_q == 5'd1 ? 8'h06 : 8'h01)
                                        : row_q[{~idx_q[3:0], 3'b000} +: 8];
`ifdef LCD_SKIP_SAME_EN
   logic [1:0][127:0] sh_q, sh_d;
   logic [1:0] vld_q, vld_d;
   assign hit = vld_q[row_sel] && ascii_row == sh_q[row_sel];
   always_comb begin
      sh_d  = sh_q;
      vld_d = vld_q;
      if (state_q == INIT) vld_d = '0;
      else if (state_q == FIN) begin
         sh_d[sel_q]  = row_q;
         vld_d[sel_q] = 1'b1;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         sh_q  <= '0;
         vld_q <= '0;
      end else begin
         sh_q  <= sh_d;
         vld_q <= vld_d;
      end
   end
`else
   assign hit = 1'b0;
`endif
   always_comb begin
      state_d = state_q;
      ph_d    = ph_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      row_d   = row_q;
      sel_d   = sel_q;
      e_d     = e_q;
      rs_d    = rs_q;
      data_d  = data_q;
      done_d  = 1'b0;
      ready_d = ready_q;
      busy_d  = busy_q;
      case (state_q)
         PWRUP:
            if (cnt_q == CW'(POWERUP_CYC - 1)) begin
               state_d = INIT;
               ph_d    = SETUP;
               cnt_d   = '0;
               idx_d   = '0;
               rs_d    = 1'b0;
               data_d  = 8'h38;
            end else cnt_d = cnt_q + 1'b1;
         INIT, WRITE:
            if (ph_q == SETUP) begin
               ph_d  = EHI;
               cnt_d = '0;
               e_d   = 1'b1;
            end else if (ph_q == EHI) begin
               if (cnt_q == CW'(E_PULSE_CYC - 1)) begin
                  ph_d  = HOLD;
                  cnt_d = '0;
                  e_d   = 1'b0;
               end else cnt_d = cnt_q + 1'b1;
            end else if (cnt_q != hold_end) cnt_d = cnt_q + 1'b1;
            else if (!last_byte) begin
               ph_d   = SETUP;
               cnt_d  = '0;
               idx_d  = idx_q + 5'd1;
               rs_d   = state_q == WRITE;
               data_d = next_byte;
            end else begin
               state_d = state_q == INIT ? IDLE : FIN;
               ready_d = 1'b1;
               busy_d  = 1'b0;
               done_d  = state_q == WRITE;
            end
         IDLE:
            if (start) begin
               row_d = ascii_row;
               sel_d = row_sel;
               if (hit) begin
                  state_d = FIN;
                  done_d  = 1'b1;
               end else begin
                  state_d = WRITE;
                  ph_d    = SETUP;
                  cnt_d   = '0;
                  idx_d   = '0;
                  busy_d  = 1'b1;
                  rs_d    = 1'b0;
                  data_d  = row_sel ? 8'hC0 : 8'h80;
               end
            end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= PWRUP;
         ph_q    <= SETUP;
         cnt_q   <= '0;
         idx_q   <= '0;
         row_q   <= '0;
         sel_q   <= 1'b0;
         e_q     <= 1'b0;
         rs_q    <= 1'b0;
         data_q  <= '0;
         done_q  <= 1'b0;
         ready_q <= 1'b0;
         busy_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         ph_q    <= ph_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         row_q   <= row_d;
         sel_q   <= sel_d;
         e_q     <= e_d;
         rs_q    <= rs_d;
         data_q  <= data_d;
         done_q  <= done_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
      end
   end
   assign ready    = ready_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign lcd_rs   = rs_q;
   assign lcd_rw   = 1'b0;
   assign lcd_e    = e_q;
   assign lcd_data = data_q;
endmodule

// File: tb/tb_lcd_row_writer.sv
// tb_lcd_row_writer: directed bench for lcd_row_writer with short timing (BYTE_CYC = 7, ready at cycle 42).
module tb_lcd_row_writer;
   logic clk = 1'b0, rst = 1'b1, row_sel = 1'b0, start = 1'b0;
   logic [127:0] ascii_row = '0;
   logic ready, busy, done, lcd_rs, lcd_rw, lcd_e;
   logic [7:0] lcd_data;
   int checks = 0, fails = 0, n = 0, e_len = 0;
   logic e_prev = 1'b0;
   bit skip_len = 1'b0;
   logic [8:0] bytes_q[$];
   localparam logic [127:0] ROW1 = "SENS: 123       ";
   localparam logic [127:0] ROW2 = "SENS: 255       ";
   localparam logic [127:0] ROW3 = "SENS: 777       ";
   localparam logic [127:0] ROW4 = "SENS: 042       ";
   localparam logic [127:0] ROW5 = "SENS: 043       ";
   logic [7:0] init_cmd [4] = '{8'h38, 8'h0C, 8'h06, 8'h01};
   logic [7:0] l1 [17] = '{8'h80, 8'h53, 8'h45, 8'h4E, 8'h53, 8'h3A, 8'h20, 8'h31, 8'h32, 8'h33,
                           8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20};
   always #5 clk = ~clk;
   lcd_row_writer #(.POWERUP_CYC(10), .E_PULSE_CYC(2), .CMD_WAIT_CYC(4), .CLEAR_WAIT_CYC(8)) dut (
      .clk(clk), .rst(rst), .ascii_row(ascii_row), .row_sel(row_sel), .start(start),
      .ready(ready), .busy(busy), .done(done), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
      .lcd_e(lcd_e), .lcd_data(lcd_data));
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   always @(negedge clk) begin
      if (lcd_e && !e_prev) begin
         bytes_q.push_back({lcd_rs, lcd_data});
         e_len = 1;
      end else if (lcd_e) e_len++;
      else if (e_prev && !skip_len) chk("e_high_len", e_len, 2);
      e_prev = lcd_e;
   end
   // call in the first cycle with rst low
   task automatic run_init;
      bytes_q.delete();
      repeat (41) tick;
      chk("init_ready_c41", ready, 0);
      tick;
      chk("init_ready_c42", ready, 1);
      chk("init_busy_c42", busy, 0);
      chk("init_nbytes", bytes_q.size(), 4);
      for (int i = 0; i < 4; i++)
         if (i < bytes_q.size()) chk("init_byte", bytes_q[i], {1'b0, init_cmd[i]});
   endtask
   task automatic do_write(input logic [127:0] row, input logic sel, input bit poke,
                           input logic exp_busy, output int cyc);
      bytes_q.delete();
      ascii_row = row;
      row_sel = sel;
      start = 1'b1;
      tick;
      start = 1'b0;
      cyc = 1;
      chk("busy_after_accept", busy, {31'd0, exp_busy});
      if (poke) begin
         ascii_row = ~row;
         row_sel = ~sel;
      end
      while (!done && cyc < 400) begin
         tick;
         cyc++;
         start = poke && cyc == 50;
      end
      start = 1'b0;
   endtask
   initial begin
      repeat (3) tick;
      chk("rst_e", lcd_e, 0);
      chk("rst_rs", lcd_rs, 0);
      chk("rst_rw", lcd_rw, 0);
      chk("rst_data", lcd_data, 0);
      chk("rst_done", done, 0);
      chk("rst_ready", ready, 0);
      chk("rst_busy", busy, 1);
      rst = 1'b0;
      run_init;
      do_write(ROW1, 1'b0, 1'b0, 1'b1, n);
      chk("l1_done_cyc", n, 120);
      chk("l1_nbytes", bytes_q.size(), 17);
      for (int i = 0; i < 17; i++)
         if (i < bytes_q.size()) chk("l1_byte", bytes_q[i], {i != 0, l1[i]});
      start = 1'b1;
      tick;
      start = 1'b0;
      chk("fin_start_done", done, 0);
      chk("fin_start_busy", busy, 0);
      repeat (10) tick;
      chk("fin_start_nbytes", bytes_q.size(), 17);
      do_write(ROW2, 1'b1, 1'b1, 1'b1, n);
      chk("l2_done_cyc", n, 120);
      chk("l2_nbytes", bytes_q.size(), 17);
      if (bytes_q.size() == 17) begin
         chk("l2_addr", bytes_q[0], 9'h0C0);
         chk("l2_char8", bytes_q[9], 9'h135);
         chk("l2_last", bytes_q[16], 9'h120);
      end
      repeat (20) tick;
      chk("l2_no_extra", bytes_q.size(), 17);
      bytes_q.delete();
      ascii_row = ROW3;
      row_sel = 1'b0;
      start = 1'b1;
      tick;
      start = 1'b0;
      repeat (36) tick;
      chk("mid_e_hi", lcd_e, 1);
      chk("mid_rs", lcd_rs, 1);
      chk("mid_data", lcd_data, 8'h3A);
      skip_len = 1'b1;
      rst = 1'b1;
      tick;
      chk("mid_rst_e", lcd_e, 0);
      chk("mid_rst_busy", busy, 1);
      chk("mid_rst_ready", ready, 0);
      chk("mid_rst_data", lcd_data, 0);
      rst = 1'b0;
      run_init;
      skip_len = 1'b0;
      do_write(ROW4, 1'b0, 1'b0, 1'b1, n);
      chk("s1_done_cyc", n, 120);
      chk("s1_nbytes", bytes_q.size(), 17);
      tick;
`ifdef LCD_SKIP_SAME_EN
      do_write(ROW4, 1'b0, 1'b0, 1'b0, n);
      chk("s2_done_cyc", n, 1);
      chk("s2_nbytes", bytes_q.size(), 0);
`else
      do_write(ROW4, 1'b0, 1'b0, 1'b1, n);
      chk("s2_done_cyc", n, 120);
      chk("s2_nbytes", bytes_q.size(), 17);
`endif
      tick;
      do_write(ROW5, 1'b0, 1'b0, 1'b1, n);
      chk("s3_done_cyc", n, 120);
      chk("s3_nbytes", bytes_q.size(), 17);
      if (bytes_q.size() == 17) chk("s3_digit", bytes_q[9], 9'h133);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
